pipe_adder: RTL
===============

// Module: pipe_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; successor to the single-cycle combinational adder.
//  Splits a WIDTH-bit add into STAGES carry-chained slices, one slice per pipeline stage.
//  Has a valid/ready handshake on both sides. Serves the ALU/AGU datapath where wide adds must meet timing.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; WIDTH % STAGES == 0 (elaboration $error otherwise)
//  STAGES  4   pipeline depth = slice count; 1 <= STAGES <= WIDTH; SLICE = WIDTH/STAGES
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands presented
//  in_ready   out  1      unit accepts operands this cycle
//  in_op      in   op_e   OP_ADD / OP_SUB
//  in_a       in   WIDTH  operand a
//  in_b       in   WIDTH  operand b
//  out_valid  out  1      result presented
//  out_ready  in   1      consumer accepts result
//  out_y      out  WIDTH  a+b or a-b, modulo 2^WIDTH
//  out_c      out  1      carry out (ADDER_FLAGS_EN only); for SUB: 1 = no borrow
//  out_v      out  1      signed overflow (ADDER_FLAGS_EN only)
//  out_z      out  1      result == 0 (ADDER_FLAGS_EN only)
// BEHAVIOUR
//  - Stage k (0..STAGES-1) holds: valid bit vk, done result bits [k*SLICE-1:0],
//    pending a/b bits above that, and a registered carry.
//  - Stage 0 inverts b and forces carry-in = 1 for OP_SUB; carry-in = 0 for OP_ADD.
//  - Stage k adds slice k using the carry registered by stage k-1.
//    It registers the slice sum and carry-out into stage k+1 (or the output register).
//  - Transfer rule, per stage: stage k advances iff vk && (stage k+1 empty || stage k+1 advances).
//    The last stage advances iff out_ready || !out_valid.
//  - in_ready = stage 0 empty || stage 0 advances; purely combinational from state and out_ready.
//    No combinational path from in_valid to in_ready.
//  - Acceptance occurs when in_valid && in_ready. Results leave in order, with no drops or duplicates.
//  - Latency is STAGES cycles from acceptance to out_valid when no stall occurs.
//    Throughput is 1 result/cycle with out_ready held high.
//  - out_valid/out_y (and flags) stay stable while out_valid && !out_ready.
//  - Full pipeline (STAGES results held) with out_ready=0: in_ready=0.
//  - Simultaneous pop and push on a full pipeline: both happen, and occupancy is unchanged.
//  - Wrap-around is modulo 2^WIDTH: 0xFFFF_FFFF+1 -> 0, with no trap.
//  - Reset (async assert, any cycle, mid-operation): all valid bits cleared and in-flight ops discarded.
//    out_valid=0, out_y=0, flags=0, in_ready=1 from the first cycle after deassert. Data registers reset to 0.
// CONFIGURATION
//  ADDER_FLAGS_EN defined:
//   - out_c/out_v/out_z exist; the flags are pipelined alongside out_y and are valid with out_valid.
//   - out_v is computed from the final slice's carry-in xor carry-out.
//  ADDER_FLAGS_EN undefined: flag ports are absent, with no flag logic and no flag registers.
//  Sum/handshake timing is identical in both builds.
// STRUCTURE
//  - adder_pkg: typedef enum logic {OP_ADD, OP_SUB} op_e;
//    function automatic int slice_w(int w, int s) returns w/s.
//  - Sub-module adder_slice #(SLICE): combinational a+b+cin -> sum, cout; instantiated STAGES times.
//  - Top level: stage registers, valid/advance chain, optional flag pipeline.
// TESTING (WIDTH=32, STAGES=4 unless noted; build with and without ADDER_FLAGS_EN)
//  1. ADD 0xFFFF_FFFF + 0x1, out_ready=1
//     -> out_valid 4 cycles later, y=0x0000_0000, c=1, z=1, v=0.
//  2. SUB 5 - 7 -> y=0xFFFF_FFFE, c=0, v=0; ADD 0x7FFF_FFFF + 1 -> y=0x8000_0000, v=1, c=0.
//  3. 8 back-to-back ADDs (i + 0x100*i), out_ready=1
//     -> 8 results on consecutive cycles, in order, values exact.
//  4. 6 ADDs pushed, out_ready=0 for 6 cycles
//     -> in_ready drops after 4 accepted; y held stable.
//     Release -> all 6 results in order, none lost.
//  5. Assert rst_n=0 with 3 ops in flight
//     -> out_valid=0, out_y=0 immediately; after release no stale results, in_ready=1.
//  6. STAGES=1, WIDTH=9: ADD 0x1FF + 0x001 -> y=0x000 after 1 cycle.
//     STAGES=8: carry ripples through all 8 stages.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared operation type and slice-width helper for pipe_adder
package adder_pkg;
  typedef enum logic {OP_ADD, OP_SUB} op_e;
  function automatic int slice_w(int w, int s);
    return w / s;
  endfunction
endpackage

// File: rtl/adder_slice.sv
// adder_slice: SLICE-bit combinational a+b+cin with carry out
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-chained add/sub pipeline with valid/ready; ADDER_FLAGS_EN adds out_c/out_v/out_z
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_e              in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
`ifdef ADDER_FLAGS_EN
  ,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z
`endif
);
  localparam int SLICE = slice_w(WIDTH, STAGES);
  localparam int L = STAGES - 1;
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad
    $error("pipe_adder: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end
  logic [STAGES-1:0] r_v, w_free, w_ld, w_cin, w_cout;
  logic              r_c   [STAGES];
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_y   [STAGES];
  logic [WIDTH-1:0]  w_a   [STAGES];
  logic [WIDTH-1:0]  w_b   [STAGES];
  logic [WIDTH-1:0]  w_y   [STAGES];
  logic [WIDTH-1:0]  w_yn  [STAGES];
  logic [SLICE-1:0]  w_sum [STAGES];
  // slice operands: ports feed slice 0, each later slice reads the previous stage register
  always_comb begin
    w_a[0] = in_a;
    w_b[0] = in_op == OP_SUB ? ~in_b : in_b;
    w_y[0] = '0;
    w_cin[0] = in_op == OP_SUB;
    for (int j = 1; j < STAGES; j++) begin
      w_a[j] = r_a[j-1];
      w_b[j] = r_b[j-1];
      w_y[j] = r_y[j-1];
      w_cin[j] = r_c[j-1];
    end
    for (int j = 0; j < STAGES; j++) begin
      w_yn[j] = w_y[j];
      w_yn[j][j*SLICE +: SLICE] = w_sum[j];
    end
  end
  // a stage can take new data unless it and every stage after it are full and the output is stalled
  always_comb begin
    for (int j = 0; j < STAGES; j++) begin
      w_free[j] = out_ready || (((~r_v) >> j) != '0);
      w_ld[j] = (j == 0 ? in_valid : r_v[j == 0 ? 0 : j-1]) && w_free[j];
    end
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    adder_slice #(.SLICE(SLICE)) u_slice (
      .i_a   (w_a[i][i*SLICE +: SLICE]),
      .i_b   (w_b[i][i*SLICE +: SLICE]),
      .i_cin (w_cin[i]),
      .o_sum (w_sum[i]),
      .o_cout(w_cout[i])
    );
  end
  // stage registers: valid follows the upstream stage whenever this stage is free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int j = 0; j < STAGES; j++) begin
        r_c[j] <= 1'b0;
        r_a[j] <= '0;
        r_b[j] <= '0;
        r_y[j] <= '0;
      end
    end else begin
      for (int j = 0; j < STAGES; j++) begin
        if (w_free[j]) r_v[j] <= w_ld[j];
        if (w_ld[j]) begin
          r_c[j] <= w_cout[j];
          r_a[j] <= w_a[j];
          r_b[j] <= w_b[j];
          r_y[j] <= w_yn[j];
        end
      end
    end
  end
  assign in_ready = w_free[0];
  assign out_valid = r_v[L];
  assign out_y = r_y[L];
`ifdef ADDER_FLAGS_EN
  logic r_z, r_ov;
  // flags captured with the final slice; overflow is carry into the MSB xor carry out, taken from sign bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z <= 1'b0;
      r_ov <= 1'b0;
    end else if (w_ld[L]) begin
      r_z <= w_yn[L] == '0;
      r_ov <= (w_a[L][WIDTH-1] == w_b[L][WIDTH-1]) && (w_sum[L][SLICE-1] != w_a[L][WIDTH-1]);
    end
  end
  assign out_c = r_c[L];
  assign out_v = r_ov;
  assign out_z = r_z;
`endif
endmodule
